// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter.
package fifo_arb_pkg;
   typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

   localparam int DW_DEF    = 8;
   localparam int DEPTH_DEF = 8;
   localparam int LEVEL_W   = $clog2(DEPTH_DEF + 1);
endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester strictly after ptr, circularly.
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  onehot,
   output logic [IW-1:0] idx,
   output logic          any
);
   logic [IW-1:0] w_c;

   always_comb begin
      onehot = '0;
      idx    = '0;
      any    = 1'b0;
      w_c    = '0;
      for (int k = 1; k <= N; k++) begin
         w_c = IW'((int'(ptr) + k) % N);
         if (!any && req[w_c]) begin
            any         = 1'b1;
            idx         = w_c;
            onehot[w_c] = 1'b1;
         end
      end
   end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for the write port of a small byte FIFO,
// with a credit counter that counts bytes at accept time so the FIFO never overruns.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int DW        = DW_DEF,
   parameter int DEPTH     = DEPTH_DEF,
   parameter int MAX_BURST = 4
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [N_REQ-1:0]           req,
   input  logic [N_REQ*DW-1:0]        req_data,
   input  logic [N_REQ-1:0]           req_last,
   output logic [N_REQ-1:0]           gnt,
   output logic [N_REQ-1:0]           ack,
   input  logic                       fifo_full,
   input  logic                       fifo_rd,
   output logic                       fifo_wr,
   output logic [DW-1:0]              fifo_data_in,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic                       busy
);
   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int LW = $clog2(DEPTH + 1);
   localparam int BW = $clog2(MAX_BURST + 1);

   state_t            r_state, w_state_nxt;
   logic [N_REQ-1:0]  r_gnt, w_gnt_nxt;
   logic [IW-1:0]     r_gidx, w_gidx_nxt;
   logic [IW-1:0]     r_ptr, w_ptr_nxt;
   logic [BW-1:0]     r_beat, w_beat_nxt;
   logic [LW-1:0]     r_level;
   logic              r_wr;
   logic [DW-1:0]     r_data;

   logic [N_REQ-1:0]  w_pick_oh;
   logic [IW-1:0]     w_pick_idx;
   logic              w_pick_any;
   logic              w_can_write, w_acc, w_release;
   logic [BW-1:0]     w_beat_inc;

   rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
      .req    (req),
      .ptr    (r_ptr),
      .onehot (w_pick_oh),
      .idx    (w_pick_idx),
      .any    (w_pick_any)
   );

   // fifo_full is only a backup: the credit count already covers the in-flight byte
   assign w_can_write = (r_level < LW'(DEPTH)) && !fifo_full;
   assign w_acc       = (r_state == BURST) && req[r_gidx] && w_can_write;
   assign w_beat_inc  = r_beat + BW'(1);
   assign w_release   = !req[r_gidx] ||
                        (w_acc && (req_last[r_gidx] || (w_beat_inc == BW'(MAX_BURST))));

   assign ack          = w_acc ? r_gnt : '0;
   assign gnt          = r_gnt;
   assign fifo_wr      = r_wr;
   assign fifo_data_in = r_data;
   assign level        = r_level;
   assign busy         = (r_state == BURST);

   always_comb begin
      w_state_nxt = r_state;
      w_gnt_nxt   = r_gnt;
      w_gidx_nxt  = r_gidx;
      w_ptr_nxt   = r_ptr;
      w_beat_nxt  = r_beat;
      case (r_state)
         IDLE: begin
            if (w_pick_any) begin
               w_state_nxt = BURST;
               w_gnt_nxt   = w_pick_oh;
               w_gidx_nxt  = w_pick_idx;
               w_beat_nxt  = '0;
            end
         end
         BURST: begin
            if (w_acc) w_beat_nxt = w_beat_inc;
            if (w_release) begin
               w_state_nxt = IDLE;
               w_gnt_nxt   = '0;
               w_ptr_nxt   = r_gidx;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_gnt   <= '0;
         r_gidx  <= '0;
         r_ptr   <= IW'(N_REQ - 1);
         r_beat  <= '0;
         r_level <= '0;
         r_wr    <= 1'b0;
         r_data  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_gnt   <= w_gnt_nxt;
         r_gidx  <= w_gidx_nxt;
         r_ptr   <= w_ptr_nxt;
         r_beat  <= w_beat_nxt;
         r_wr    <= w_acc;
         if (w_acc) r_data <= req_data[r_gidx*DW +: DW];
         case ({w_acc, fifo_rd && (r_level != '0)})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a cycle reference model.
module tb_fifo_wr_arbiter;
   logic        clk = 1'b0;
   logic        reset_n;
   logic [3:0]  req, req_last, gnt, ack;
   logic [31:0] req_data;
   logic        fifo_full, fifo_rd, fifo_wr, busy;
   logic [7:0]  fifo_data_in;
   logic [3:0]  level;

   int n_cmp = 0;
   int n_err = 0;

   // reference model: granted producer (-1 = none), last winner, beats, credits, write reg
   int         m_g, m_ptr, m_beat, m_level;
   logic       m_wr;
   logic [7:0] m_data;

   fifo_wr_arbiter dut (
      .clk(clk), .reset_n(reset_n), .req(req), .req_data(req_data), .req_last(req_last),
      .gnt(gnt), .ack(ack), .fifo_full(fifo_full), .fifo_rd(fifo_rd), .fifo_wr(fifo_wr),
      .fifo_data_in(fifo_data_in), .level(level), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got running required done");
      $fatal(1, "watchdog");
   end

   function automatic logic [3:0] m_ackv();
      if (m_g >= 0 && req[m_g] && m_level < 8 && !fifo_full) return 4'(1 << m_g);
      return 4'b0;
   endfunction

   function automatic logic [3:0] m_gntv();
      return (m_g >= 0) ? 4'(1 << m_g) : 4'b0;
   endfunction

   task automatic model_reset();
      m_g = -1; m_ptr = 3; m_beat = 0; m_level = 0; m_wr = 1'b0; m_data = 8'h00;
   endtask

   // one clock edge; model consumes the inputs that were stable across the edge
   task automatic step();
      logic [3:0] a;
      a = m_ackv();
      @(posedge clk);
      m_level = m_level + ((a != 0) ? 1 : 0) - ((fifo_rd && m_level > 0) ? 1 : 0);
      m_wr = (a != 0);
      if (a != 0) m_data = req_data[m_g*8 +: 8];
      if (m_g < 0) begin
         for (int k = 1; k <= 4; k++) begin
            if (m_g < 0 && req[(m_ptr + k) % 4]) begin
               m_g = (m_ptr + k) % 4;
               m_beat = 0;
            end
         end
      end else if (!req[m_g]) begin
         m_ptr = m_g; m_g = -1;
      end else if (a != 0) begin
         m_beat++;
         if (req_last[m_g] || m_beat == 4) begin
            m_ptr = m_g; m_g = -1;
         end
      end
      #1;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset_n = 1'b0;
      req = '0; req_last = '0; req_data = '0; fifo_full = 1'b0; fifo_rd = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      step();
   endtask

   task automatic test_reset();
      apply_reset();
      n_cmp++;
      if ({gnt, fifo_wr, fifo_data_in, level, busy} !== 18'b0) begin
         n_err++;
         $display("FAIL reset_state: got gnt=%b wr=%b data=%h level=%0d busy=%b required all 0",
                  gnt, fifo_wr, fifo_data_in, level, busy);
      end
   endtask

   task automatic test_single();
      apply_reset();
      req = 4'b0001; req_last = 4'b0001; req_data = 32'h0000_00A5;
      #1;
      n_cmp++;
      if (ack !== 4'b0000) begin n_err++; $display("FAIL single_idle_ack: got %b required 0000", ack); end
      step();
      n_cmp++;
      if (gnt !== 4'b0001) begin n_err++; $display("FAIL single_gnt: got %b required 0001", gnt); end
      n_cmp++;
      if (ack !== 4'b0001) begin n_err++; $display("FAIL single_ack: got %b required 0001", ack); end
      step();
      req = 4'b0000;
      n_cmp++;
      if (fifo_wr !== 1'b1 || fifo_data_in !== 8'hA5) begin
         n_err++; $display("FAIL single_write: got wr=%b data=%h required wr=1 data=a5", fifo_wr, fifo_data_in);
      end
      n_cmp++;
      if (level !== 4'd1 || gnt !== 4'b0 || busy !== 1'b0) begin
         n_err++; $display("FAIL single_after: got level=%0d gnt=%b busy=%b required 1 0000 0", level, gnt, busy);
      end
      step();
      n_cmp++;
      if (fifo_wr !== 1'b0 || fifo_data_in !== 8'hA5) begin
         n_err++; $display("FAIL single_wr_drop: got wr=%b data=%h required wr=0 data=a5", fifo_wr, fifo_data_in);
      end
   endtask

   // all four stream; every 5th cycle is the arbitration gap, bursts rotate 0,1,2,3,0
   task automatic test_round_robin();
      logic [3:0] exp;
      apply_reset();
      fifo_rd = 1'b1; req = 4'b1111; req_last = 4'b0000;
      for (int i = 0; i < 25; i++) begin
         req_data = $urandom;
         #1;
         exp = (i % 5 == 0) ? 4'b0000 : 4'(1 << ((i / 5) % 4));
         n_cmp++;
         if (ack !== exp) begin
            n_err++; $display("FAIL rr_ack cycle %0d: got %b required %b", i, ack, exp);
         end
         step();
         if (exp != 0) begin
            n_cmp++;
            if (fifo_wr !== 1'b1 || fifo_data_in !== m_data) begin
               n_err++; $display("FAIL rr_data cycle %0d: got wr=%b %h required wr=1 %h", i, fifo_wr, fifo_data_in, m_data);
            end
         end
      end
      fifo_rd = 1'b0; req = '0;
   endtask

   task automatic test_full();
      int acks;
      apply_reset();
      req = 4'b0001; req_last = 4'b0000; req_data = 32'h0000_003C;
      acks = 0;
      for (int i = 0; i < 24; i++) begin
         #1;
         if (ack != 0) acks++;
         step();
      end
      n_cmp++;
      if (acks != 8) begin n_err++; $display("FAIL full_ack_count: got %0d required 8", acks); end
      n_cmp++;
      if (level !== 4'd8 || gnt !== 4'b0001 || ack !== 4'b0000) begin
         n_err++; $display("FAIL full_stall: got level=%0d gnt=%b ack=%b required 8 0001 0000", level, gnt, ack);
      end
      fifo_rd = 1'b1;
      step();
      fifo_rd = 1'b0;
      acks = 0;
      for (int i = 0; i < 6; i++) begin
         #1;
         if (ack != 0) acks++;
         step();
      end
      n_cmp++;
      if (acks != 1 || level !== 4'd8) begin
         n_err++; $display("FAIL full_one_more: got acks=%0d level=%0d required 1 8", acks, level);
      end
      req = '0;
   endtask

   task automatic test_level_edges();
      bit found;
      apply_reset();
      req = 4'b0001; req_last = 4'b0000; req_data = 32'h0000_0011;
      found = 1'b0;
      for (int i = 0; i < 30; i++) begin
         #1;
         if (m_level == 5 && ack != 0) begin found = 1'b1; break; end
         step();
      end
      n_cmp++;
      if (!found) begin
         n_err++; $display("FAIL level5_reach: got level=%0d required ack at level 5", level);
      end else begin
         fifo_rd = 1'b1;
         step();
         fifo_rd = 1'b0;
         n_cmp++;
         if (level !== 4'd5) begin n_err++; $display("FAIL ack_and_rd: got %0d required 5", level); end
      end
      apply_reset();
      fifo_rd = 1'b1;
      step(); step();
      n_cmp++;
      if (level !== 4'd0) begin n_err++; $display("FAIL rd_at_zero: got %0d required 0", level); end
      fifo_rd = 1'b0;
   endtask

   task automatic test_abandon();
      int acks;
      logic [3:0] nxt, exp_g;
      for (int v = 0; v < 2; v++) begin
         nxt   = (v == 0) ? 4'b1000 : 4'b0001;
         exp_g = nxt;
         apply_reset();
         req = 4'b0100; req_last = 4'b0000; req_data = 32'h0077_0000;
         acks = 0;
         for (int i = 0; i < 10 && acks < 2; i++) begin
            #1;
            if (ack != 0) acks++;
            step();
         end
         req = nxt;
         #1;
         n_cmp++;
         if (ack !== 4'b0000) begin n_err++; $display("FAIL abandon_ack v%0d: got %b required 0000", v, ack); end
         step();
         n_cmp++;
         if (gnt !== 4'b0000 || level !== 4'd2) begin
            n_err++; $display("FAIL abandon_release v%0d: got gnt=%b level=%0d required 0000 2", v, gnt, level);
         end
         step();
         n_cmp++;
         if (gnt !== exp_g) begin n_err++; $display("FAIL abandon_next v%0d: got %b required %b", v, gnt, exp_g); end
      end
      req = '0;
   endtask

   task automatic test_reset_mid();
      apply_reset();
      req = 4'b0001; req_last = 4'b0000; req_data = 32'h0000_005A;
      step(); step();
      #2;
      reset_n = 1'b0;
      #1;
      n_cmp++;
      if (gnt !== 4'b0 || fifo_wr !== 1'b0 || level !== 4'd0 || busy !== 1'b0) begin
         n_err++; $display("FAIL async_reset: got gnt=%b wr=%b level=%0d busy=%b required 0000 0 0 0",
                           gnt, fifo_wr, level, busy);
      end
      model_reset();
      req = 4'b0000;
      @(negedge clk);
      reset_n = 1'b1;
      step();
      req = 4'b0011;
      step();
      n_cmp++;
      if (gnt !== 4'b0001) begin n_err++; $display("FAIL reset_first_winner: got %b required 0001", gnt); end
      req = '0;
   endtask

   task automatic test_random();
      int bad;
      apply_reset();
      bad = 0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
         req_last  = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
         req_data  = $urandom;
         fifo_full = ($urandom_range(0, 9) == 0);
         fifo_rd   = ($urandom_range(0, 1) == 0);
         #1;
         n_cmp++;
         if (ack !== m_ackv()) begin
            n_err++; bad++;
            if (bad < 10) $display("FAIL rand_ack cycle %0d: got %b required %b", i, ack, m_ackv());
         end
         step();
         n_cmp++;
         if (gnt !== m_gntv() || fifo_wr !== m_wr || fifo_data_in !== m_data ||
             level !== 4'(m_level) || busy !== (m_g >= 0)) begin
            n_err++; bad++;
            if (bad < 10)
               $display("FAIL rand_regs cycle %0d: got gnt=%b wr=%b d=%h lvl=%0d busy=%b required %b %b %h %0d %b",
                        i, gnt, fifo_wr, fifo_data_in, level, busy, m_gntv(), m_wr, m_data, m_level, m_g >= 0);
         end
      end
      req = '0; fifo_rd = 1'b0; fifo_full = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0;
      req = '0; req_last = '0; req_data = '0; fifo_full = 1'b0; fifo_rd = 1'b0;
      model_reset();
      test_reset();
      test_single();
      test_round_robin();
      test_full();
      test_level_edges();
      test_abandon();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
